// File: rtl/stdio_uart_if.sv
// stdio: val/data/rdy word channel shared by the stdout sink and stdin source.
interface stdio;
    logic        val;
    logic [15:0] data;
    logic        rdy;
    modport in  (input val, data, output rdy);
    modport out (output val, data, input rdy);
endinterface

// File: rtl/stdio_uart.sv
// stdio_uart: stdout/stdin word FIFOs bridged to a UART pin pair, two bytes per word (hi first).
// Define STDIO_UART_PARITY_EN for 8E1 framing with parity checking; default is 8N1.
module stdio_uart #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    stdio.in     stdout_intf,
    stdio.out    stdin_intf,
    input  logic uart_rx_i,
    output logic uart_tx_o,
    input  logic err_clr_i,
    output logic frame_err_o,
    output logic ovf_err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef STDIO_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, HOLD} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, HOLD} state_e;
`endif

    function automatic logic full_f(input logic [AW:0] w, input logic [AW:0] r);
        return (w ^ r) == {1'b1, {AW{1'b0}}};
    endfunction

    logic [15:0]   tx_mem_q [FIFO_DEPTH];
    logic [15:0]   rx_mem_q [FIFO_DEPTH];
    logic [AW:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic          tx_rdy_q, tx_push, tx_pop, tx_empty, rx_push, rx_acc, rx_pop, rx_empty, rx_full;
    logic [15:0]   tx_head;
    state_e        tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]    tx_byte_q, tx_byte_d, tx_lo_q, tx_lo_d, rx_byte_q, rx_byte_d, rx_hi_q, rx_hi_d;
    logic          tx_hi_q, tx_hi_d, tx_q, tx_d, tx_tick, rx_tick, rx_ok, rx_ph_q, rx_ph_d;
    logic          rx_s1_q, rx_s2_q, rx_s3_q, ferr_set, ferr_q, ferr_d, ovf_q, ovf_d;
`ifdef STDIO_UART_PARITY_EN
    logic          rx_perr_q, rx_perr_d;
    assign rx_ok = rx_s2_q && !rx_perr_q;
`else
    assign rx_ok = rx_s2_q;
`endif

    assign tx_push  = stdout_intf.val && tx_rdy_q;
    assign tx_empty = tx_wr_q == tx_rd_q;
    assign tx_head  = tx_mem_q[tx_rd_q[AW-1:0]];
    assign tx_wr_d  = tx_wr_q + (AW+1)'(tx_push);
    assign tx_rd_d  = tx_rd_q + (AW+1)'(tx_pop);
    assign rx_empty = rx_wr_q == rx_rd_q;
    assign rx_full  = full_f(rx_wr_q, rx_rd_q);
    assign rx_acc   = rx_push && !rx_full;
    assign rx_pop   = !rx_empty && stdin_intf.rdy;
    assign rx_wr_d  = rx_wr_q + (AW+1)'(rx_acc);
    assign rx_rd_d  = rx_rd_q + (AW+1)'(rx_pop);
    assign ferr_d   = ferr_set || (ferr_q && !err_clr_i);
    assign ovf_d    = (rx_push && rx_full) || (ovf_q && !err_clr_i);

    assign stdout_intf.rdy = tx_rdy_q;
    assign stdin_intf.val  = !rx_empty;
    assign stdin_intf.data = rx_mem_q[rx_rd_q[AW-1:0]];
    assign uart_tx_o       = tx_q;
    assign frame_err_o     = ferr_q;
    assign ovf_err_o       = ovf_q;

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_tick   = tx_cnt_q == BIT_END;
        tx_cnt_d  = tx_tick ? '0 : tx_cnt_q + CW'(1);
        tx_bit_d  = tx_bit_q;
        tx_byte_d = tx_byte_q;
        tx_lo_d   = tx_lo_q;
        tx_hi_d   = tx_hi_q;
        tx_d      = tx_q;
        tx_pop    = 1'b0;
        case (tx_st_q)
            IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop               = 1'b1;
                    {tx_byte_d, tx_lo_d} = tx_head;
                    tx_hi_d              = 1'b1;
                    tx_st_d              = START;
                    tx_d                 = 1'b0;
                end
            end
            START: if (tx_tick) begin
                tx_st_d  = DATA;
                tx_bit_d = '0;
                tx_d     = tx_byte_q[0];
            end
            DATA: if (tx_tick) begin
                if (tx_bit_q == 3'd7) begin
`ifdef STDIO_UART_PARITY_EN
                    tx_st_d = PARITY;
                    tx_d    = ^tx_byte_q;
`else
                    tx_st_d = STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_d     = tx_byte_q[tx_bit_q + 3'd1];
                end
            end
`ifdef STDIO_UART_PARITY_EN
            PARITY: if (tx_tick) begin
                tx_st_d = STOP;
                tx_d    = 1'b1;
            end
`endif
            STOP: if (tx_tick) begin
                // hi byte's stop runs straight into the lo byte's start
                tx_st_d   = tx_hi_q ? START : IDLE;
                tx_d      = !tx_hi_q;
                tx_byte_d = tx_lo_q;
                tx_hi_d   = 1'b0;
            end
            default: tx_st_d = IDLE;
        endcase
    end

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_tick   = rx_cnt_q == BIT_END;
        rx_cnt_d  = rx_tick ? '0 : rx_cnt_q + CW'(1);
        rx_bit_d  = rx_bit_q;
        rx_byte_d = rx_byte_q;
        rx_hi_d   = rx_hi_q;
        rx_ph_d   = rx_ph_q;
        rx_push   = 1'b0;
        ferr_set  = 1'b0;
`ifdef STDIO_UART_PARITY_EN
        rx_perr_d = rx_perr_q;
`endif
        case (rx_st_q)
            IDLE: begin
                rx_cnt_d = '0;
                if (rx_s3_q && !rx_s2_q) rx_st_d = START;
            end
            START: if (rx_cnt_q == HALF_END) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s2_q ? IDLE : DATA;
            end
            DATA: if (rx_tick) begin
                rx_byte_d = {rx_s2_q, rx_byte_q[7:1]};
                rx_bit_d  = rx_bit_q + 3'd1;
`ifdef STDIO_UART_PARITY_EN
                if (rx_bit_q == 3'd7) rx_st_d = PARITY;
`else
                if (rx_bit_q == 3'd7) rx_st_d = STOP;
`endif
            end
`ifdef STDIO_UART_PARITY_EN
            PARITY: if (rx_tick) begin
                rx_perr_d = rx_s2_q ^ (^rx_byte_q);
                rx_st_d   = STOP;
            end
`endif
            STOP: if (rx_tick) begin
                if (rx_ok) begin
                    rx_st_d = IDLE;
                    rx_ph_d = !rx_ph_q;
                    rx_hi_d = rx_ph_q ? rx_hi_q : rx_byte_q;
                    rx_push = rx_ph_q;
                end else begin
                    ferr_set = 1'b1;
                    rx_ph_d  = 1'b0;
                    rx_st_d  = HOLD;
                end
            end
            HOLD: begin
                rx_cnt_d = '0;
                if (rx_s2_q) rx_st_d = IDLE;
            end
            default: rx_st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= stdout_intf.data;
        if (rx_acc) rx_mem_q[rx_wr_q[AW-1:0]] <= {rx_hi_q, rx_byte_q};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            tx_rdy_q  <= 1'b0;
            tx_st_q   <= IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_byte_q <= '0;
            tx_lo_q   <= '0;
            tx_hi_q   <= 1'b0;
            tx_q      <= 1'b1;
            rx_st_q   <= IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_byte_q <= '0;
            rx_hi_q   <= '0;
            rx_ph_q   <= 1'b0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef STDIO_UART_PARITY_EN
            rx_perr_q <= 1'b0;
`endif
        end else begin
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            tx_rdy_q  <= !full_f(tx_wr_d, tx_rd_d);
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_byte_q <= tx_byte_d;
            tx_lo_q   <= tx_lo_d;
            tx_hi_q   <= tx_hi_d;
            tx_q      <= tx_d;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_byte_q <= rx_byte_d;
            rx_hi_q   <= rx_hi_d;
            rx_ph_q   <= rx_ph_d;
            rx_s1_q   <= uart_rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
`ifdef STDIO_UART_PARITY_EN
            rx_perr_q <= rx_perr_d;
`endif
        end
    end
endmodule
